data_mem_responder: RTL and testbench

- Memory-side responder for the core's data port. It accepts the MEM-stage access (address, write data, write enable, byte enables, request) and runs it on a simple req/ack system bus.
- It returns read data and drives memValid, the stall handshake the core's hazard unit consumes.
- A bus timeout converts a hung slave into an error response, so the pipeline never deadlocks.

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_timeout_counter.sv | 47 ++++
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-port memory responder: state encoding,
// default error data, bus lane constant and a width helper.
package data_mem_responder_pkg;

  // Responder FSM states, 2-bit registered encoding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  // Read data returned to the core when a load times out.
  localparam logic [31:0] DefaultErrData = 32'hDEADBEEF;

  // Byte enables used for every read: the whole word is fetched.
  localparam logic [3:0] BeAllLanes = 4'b1111;

  // Ceiling log2 for sizing counters; clog2_fn(1) = 0.
  function automatic int unsigned clog2_fn(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/data_mem_responder_timeout_counter.sv
// Saturating cycle counter used to bound how long the responder waits for
// a bus acknowledge. tc_o flags the last allowed wait cycle.
module bus_timeout_counter
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // One spare bit above clog2 so the terminal value always fits.
  localparam int unsigned CntW = clog2_fn(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is decoded from the current value, so it is seen in the
  // same cycle the counter holds TIMEOUT_CYCLES-1.
  always_comb begin
    tc_o = (cnt_q == CntLast);
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port. Runs each MEM-stage access
// as one req/ack bus transaction, returns registered load data, stalls the
// core via memValid, and turns a hung slave into an error response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DefaultErrData
) (
  input  logic        clk,
  input  logic        rst_n,
  // Core side
  input  logic        reqEn,
  input  logic        reqWe,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  input  logic [3:0]  reqBe,
  output logic        memValid,
  output logic [31:0] rdData,
  // System bus side
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  // Error reporting
  output logic        errFlag,
  output logic [31:0] errAddr,
  input  logic        errClr
);

  state_e state_d, state_q;

  logic        bus_req_d,   bus_req_q;
  logic        bus_we_d,    bus_we_q;
  logic [31:0] bus_addr_d,  bus_addr_q;
  logic [31:0] bus_wdata_d, bus_wdata_q;
  logic [3:0]  bus_be_d,    bus_be_q;
  logic [31:0] rd_data_d,   rd_data_q;
  logic        err_flag_d,  err_flag_q;
  logic [31:0] err_addr_d,  err_addr_q;

  logic accept;
  logic ack_done;
  logic timeout_done;
  logic timeout_tc;
  logic mem_valid;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    accept       = (state_q == StIdle) && reqEn;
    ack_done     = (state_q == StBus) && busAck;
    // An ack on the terminal cycle is a success, so it masks the timeout.
    timeout_done = (state_q == StBus) && !busAck && timeout_tc;
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (state_q == StBus),
    .tc_o  (timeout_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: RESP always lasts one cycle, so a held request is not
  // picked up again until the core presents it in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (reqEn) state_d = StBus;
      StBus:   if (ack_done || timeout_done) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: memValid is low only while an access is in flight.
  always_comb begin
    mem_valid = 1'b0;
    unique case (state_q)
      StIdle:  mem_valid = ~reqEn;
      StBus:   mem_valid = 1'b0;
      StResp:  mem_valid = 1'b1;
      default: mem_valid = ~reqEn;
    endcase
  end

  // Bus, read-data and error register next-state.
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rd_data_d   = rd_data_q;
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;

    if (accept) begin
      bus_req_d   = 1'b1;
      bus_we_d    = reqWe;
      bus_addr_d  = {reqAddr[31:2], 2'b00};
      bus_wdata_d = reqWdata;
      bus_be_d    = reqWe ? reqBe : BeAllLanes;
    end

    if (ack_done) begin
      bus_req_d = 1'b0;
      if (!bus_we_q) begin
        rd_data_d = busRdata;
      end
    end

    if (timeout_done) begin
      bus_req_d = 1'b0;
      if (!bus_we_q) begin
        rd_data_d = ERR_DATA;
      end
    end

    // Only the first timeout is recorded; a clear in the same cycle wins.
    // reqAddr is still the faulting address because the core is stalled.
    if (errClr) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
    end else if (timeout_done && !err_flag_q) begin
      err_flag_d = 1'b1;
      err_addr_d = reqAddr;
    end
  end

  // Bus, read-data and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      rd_data_q   <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rd_data_q   <= rd_data_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign memValid = mem_valid;
  assign rdData   = rd_data_q;
  assign busReq   = bus_req_q;
  assign busWe    = bus_we_q;
  assign busAddr  = bus_addr_q;
  assign busWdata = bus_wdata_q;
  assign busBe    = bus_be_q;
  assign errFlag  = err_flag_q;
  assign errAddr  = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder with a 4-cycle timeout.
module tb_data_mem_responder;

  localparam int unsigned Timeout = 4;
  localparam logic [31:0] ErrData = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqEn = 1'b0;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [3:0]  reqBe = '0;
  logic        memValid;
  logic [31:0] rdData;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic [31:0] busRdata = '0;
  logic        busAck = 1'b0;
  logic        errFlag;
  logic [31:0] errAddr;
  logic        errClr = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .TIMEOUT_CYCLES (Timeout),
    .ERR_DATA       (ErrData)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reqEn    (reqEn),
    .reqWe    (reqWe),
    .reqAddr  (reqAddr),
    .reqWdata (reqWdata),
    .reqBe    (reqBe),
    .memValid (memValid),
    .rdData   (rdData),
    .busReq   (busReq),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWdata (busWdata),
    .busBe    (busBe),
    .busRdata (busRdata),
    .busAck   (busAck),
    .errFlag  (errFlag),
    .errAddr  (errAddr),
    .errClr   (errClr)
  );

  typedef struct {
    logic [31:0] rd;
    logic        flag;
    logic [31:0] addr;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  logic [31:0] m_rd   = '0;
  logic        m_flag = 1'b0;
  logic [31:0] m_addr = '0;

  // Transaction currently on the bus, as planned by the driver.
  logic [31:0] cur_addr  = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] cur_rdata = '0;
  logic        cur_we    = 1'b0;
  logic [3:0]  cur_be    = '0;
  int          cur_delay = 0;

  bit slave_en = 1'b0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks in BUS cycle cur_delay+1 (never if the delay reaches the
  // timeout), throws stray acks when idle, and checks the bus fields.
  int bus_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!slave_en) begin
        bus_cyc = 0;
      end else if (busReq) begin
        check("busAddr", busAddr, {cur_addr[31:2], 2'b00});
        check("busWe", busWe, cur_we);
        check("busBe", busBe, cur_we ? cur_be : 4'hF);
        check("busWdata", busWdata, cur_wdata);
        busAck   = (bus_cyc == cur_delay);
        busRdata = busAck ? cur_rdata : $urandom;
        bus_cyc++;
      end else begin
        if (bus_cyc != 0) begin
          check("busReq_len", bus_cyc,
                (cur_delay < int'(Timeout)) ? cur_delay + 1 : int'(Timeout));
          bus_cyc = 0;
        end
        busAck   = ($urandom_range(0, 7) == 0);
        busRdata = $urandom;
      end
    end
  end

  // Monitor: compares every response cycle against the scoreboard.
  int stall = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall = 0;
      end else if (!reqEn) begin
        check("memValid_idle", memValid, 1'b1);
        stall = 0;
      end else if (!memValid) begin
        stall++;
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got memValid=1 expected no response at %0t", $time);
        stall = 0;
      end else begin
        e = exp_q.pop_front();
        check("rdData", rdData, e.rd);
        check("errFlag", errFlag, e.flag);
        check("errAddr", errAddr, e.addr);
        check("stall_cycles", stall, e.stall);
        stall = 0;
      end
    end
  end

  // Presents one access, records its expected outcome, and returns one step
  // after the response cycle (state back in IDLE, reqEn still high).
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                       input bit clr_hold);
    bit timeout;
    int n;
    cur_addr  = addr;
    cur_we    = we;
    cur_be    = be;
    cur_wdata = wdata;
    cur_rdata = rdata;
    cur_delay = delay;
    reqEn     = 1'b1;
    reqWe     = we;
    reqAddr   = addr;
    reqBe     = be;
    reqWdata  = wdata;
    errClr    = clr_hold;

    timeout = (delay >= int'(Timeout));
    if (!we) m_rd = timeout ? ErrData : rdata;
    if (clr_hold) begin
      m_flag = 1'b0;
      m_addr = '0;
    end else if (timeout && !m_flag) begin
      m_flag = 1'b1;
      m_addr = addr;
    end
    exp_q.push_back('{m_rd, m_flag, m_addr, timeout ? 1 + int'(Timeout) : delay + 2});

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!memValid && n < 64);
    if (!memValid) begin
      $display("FAIL resp_timeout: got no memValid expected response within 64 cycles");
      $fatal(1, "responder hung");
    end
    @(posedge clk);
    #1;
    errClr = 1'b0;
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_memValid_noreq", memValid, 1'b1);
    check("rst_busReq", busReq, 1'b0);
    check("rst_busWe", busWe, 1'b0);
    check("rst_busAddr", busAddr, 32'h0);
    check("rst_busWdata", busWdata, 32'h0);
    check("rst_busBe", busBe, 4'h0);
    check("rst_rdData", rdData, 32'h0);
    check("rst_errFlag", errFlag, 1'b0);
    check("rst_errAddr", errAddr, 32'h0);
    reqEn = 1'b1;
    #1;
    check("rst_memValid_req", memValid, 1'b0);
    reqEn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en   = 1'b1;
    slave_en = 1'b1;

    // Directed cases.
    issue(32'h0000_1006, 1'b0, 4'h0, 32'h1111_2222, 32'hA5A5_1234, 0, 1'b0);
    issue(32'h0000_2000, 1'b1, 4'b0011, 32'h0000_BEEF, 32'h5555_5555, 3, 1'b0);
    issue(32'h0000_3008, 1'b0, 4'h0, 32'h0, 32'h7777_7777, 9, 1'b0);
    issue(32'h0000_400C, 1'b0, 4'h0, 32'h0, 32'h8888_8888, 9, 1'b0);
    reqEn  = 1'b0;
    errClr = 1'b1;
    m_flag = 1'b0;
    m_addr = '0;
    @(posedge clk);
    #1;
    errClr = 1'b0;
    issue(32'h0000_5004, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 3, 1'b0);
    issue(32'h0000_6000, 1'b0, 4'h0, 32'h0, 32'h0BAD_F00D, 9, 1'b1);

    // Randomised traffic with back-to-back, idle gaps and error clears.
    repeat (150) begin
      issue($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
            $urandom_range(0, 5), ($urandom_range(0, 9) == 0));
      case ($urandom_range(0, 3))
        0, 1: ;
        2: begin
          reqEn   = 1'b0;
          reqAddr = $urandom;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        default: begin
          reqEn  = 1'b0;
          errClr = 1'b1;
          m_flag = 1'b0;
          m_addr = '0;
          @(posedge clk);
          #1;
          errClr = 1'b0;
        end
      endcase
    end

    // Reset during a pending read.
    reqEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en   = 1'b0;
    slave_en = 1'b0;
    busAck   = 1'b0;
    reqEn    = 1'b1;
    reqWe    = 1'b0;
    reqAddr  = 32'h0000_9000;
    repeat (2) @(posedge clk);
    #2;
    check("mid_bus_busReq", busReq, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_bus_busReq", busReq, 1'b0);
    check("rst_bus_memValid_req", memValid, 1'b0);
    check("rst_bus_rdData", rdData, 32'h0);
    check("rst_bus_busAddr", busAddr, 32'h0);
    reqEn = 1'b0;
    #1;
    check("rst_bus_memValid_noreq", memValid, 1'b1);
    @(negedge clk);
    rst_n  = 1'b1;
    busAck = 1'b1;
    busRdata = 32'hFEED_FACE;
    @(negedge clk);
    busAck = 1'b0;
    @(negedge clk);
    check("late_ack_busReq", busReq, 1'b0);
    check("late_ack_memValid", memValid, 1'b1);
    check("late_ack_rdData", rdData, 32'h0);
    @(posedge clk);
    #1;
    exp_q.delete();
    m_rd   = '0;
    m_flag = 1'b0;
    m_addr = '0;
    mon_en   = 1'b1;
    slave_en = 1'b1;
    issue(32'h0000_A004, 1'b0, 4'h0, 32'h0, 32'hCAFE_0001, 1, 1'b0);
    reqEn = 1'b0;
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
